bus_share_arbiter: RTL and testbench

- Two-requester arbiter that shares the processor's single 8-bit internal bus.
- Drives the select line of the 2:1 bus mux.
- Registers the selected byte onto the bus with a valid strobe.
- Round-robin on contention, with a bounded hold time so neither requester can starve the other.

---
 rtl/bus_share_arbiter_if.sv | 12 +
 rtl/bus_share_arbiter.sv | 60 ++++++
 tb/tb_bus_share_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/bus_share_arbiter_if.sv
// bus_share_arbiter_if: requester/bus signal bundle shared by the arbiter and its requesters.
interface bus_share_arbiter_if #(parameter int WIDTH = 8);
   logic [1:0]       req;
   logic [WIDTH-1:0] data0;
   logic [WIDTH-1:0] data1;
   logic [1:0]       gnt;
   logic             sel;
   logic [WIDTH-1:0] bus_out;
   logic             bus_valid;
   modport master (output req, data0, data1, input gnt, sel, bus_out, bus_valid);
   modport slave (input req, data0, data1, output gnt, sel, bus_out, bus_valid);
endinterface

// File: rtl/bus_share_arbiter.sv
// bus_share_arbiter: two-requester round-robin bus arbiter with bounded hold and registered bus output.
// Define ARB_FIXED_PRIO_EN for fixed priority to requester 0 (requester 1 never preempted).
module bus_share_arbiter #(
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 4
) (
   input logic              clk,
   input logic              rst_n,
   bus_share_arbiter_if.slave bus
);
`ifdef ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif
   localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
   state_t     state, nxt;
   logic       last;
   logic [3:0] hold_cnt;
   logic       hold_done;
   assign hold_done = hold_cnt == HOLD_LAST;
   always_comb begin
      nxt = state;
      case (state)
         IDLE: nxt = (bus.req == 2'b01) ? GNT0 :
                     (bus.req == 2'b10) ? GNT1 :
                     (bus.req == 2'b11) ? ((FIXED || last) ? GNT0 : GNT1) : IDLE;
         GNT0: nxt = !bus.req[0] ? (bus.req[1] ? GNT1 : IDLE) :
                     (bus.req[1] && hold_done) ? GNT1 : GNT0;
         GNT1: nxt = !bus.req[1] ? (bus.req[0] ? GNT0 : IDLE) :
                     (bus.req[0] && hold_done && !FIXED) ? GNT0 : GNT1;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         last          <= 1'b1;
         hold_cnt      <= 4'd0;
         bus.gnt       <= 2'b00;
         bus.sel       <= 1'b0;
         bus.bus_out   <= {WIDTH{1'b0}};
         bus.bus_valid <= 1'b0;
      end else begin
         state   <= nxt;
         bus.gnt <= (nxt == GNT0) ? 2'b01 : (nxt == GNT1) ? 2'b10 : 2'b00;
         // sel parks on the previous owner while idle
         bus.sel <= (nxt == GNT1) ? 1'b1 : (nxt == GNT0) ? 1'b0 : bus.sel;
         if (nxt != state && nxt != IDLE) begin
            last     <= nxt == GNT1;
            hold_cnt <= 4'd0;
         end else if (nxt != IDLE && !hold_done) begin
            hold_cnt <= hold_cnt + 4'd1;
         end
         bus.bus_valid <= |bus.gnt;
         if (|bus.gnt) bus.bus_out <= bus.sel ? bus.data1 : bus.data0;
      end
   end
endmodule

// File: tb/tb_bus_share_arbiter.sv
// tb_bus_share_arbiter: directed vector table plus randomized run against a run-length reference model.
module tb_bus_share_arbiter;
`ifdef ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   always #5 clk = ~clk;
   bus_share_arbiter_if #(.WIDTH(8)) b4 ();
   bus_share_arbiter_if #(.WIDTH(8)) b1 ();
   bus_share_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
   bus_share_arbiter #(.WIDTH(8), .MAX_HOLD(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   typedef struct packed {
      int         owner;
      int         last;
      int         run;
      logic [1:0] gnt;
      logic       sel;
      logic       valid;
      logic [7:0] out;
   } model_t;
   typedef struct packed {
      logic       rn;
      logic [1:0] req;
      logic [7:0] d0;
      logic [7:0] d1;
      logic [1:0] g;
      logic       s;
      logic       v;
      logic [7:0] o;
   } vec_t;
   model_t m4, m1;
   vec_t   tab[$];
   // owner = -1 when idle; run counts consecutive granted cycles including the current one
   function automatic model_t mstep(model_t m, int mh, logic rn, logic [1:0] r, logic [7:0] a, logic [7:0] b);
      model_t n = m;
      int     nw;
      int     i;
      int     j;
      if (!rn) begin
         n.owner = -1; n.last = 1; n.run = 0; n.gnt = 2'b00; n.sel = 1'b0; n.valid = 1'b0; n.out = 8'h00;
         return n;
      end
      n.valid = m.owner >= 0;
      if (n.valid) n.out = m.sel ? b : a;
      if (m.owner < 0) begin
         nw = (r == 2'b00) ? -1 : (r == 2'b01) ? 0 : (r == 2'b10) ? 1 : (FIXED ? 0 : 1 - m.last);
      end else begin
         i = m.owner;
         j = 1 - i;
         if (!r[i]) nw = r[j] ? j : -1;
         else if (r[j] && m.run >= mh && !(FIXED && i == 1)) nw = j;
         else nw = i;
      end
      if (nw >= 0 && nw != m.owner) begin
         n.last = nw;
         n.run = 1;
      end else if (nw >= 0) begin
         n.run = m.run + 1;
      end
      n.owner = nw;
      n.gnt = (nw == 0) ? 2'b01 : (nw == 1) ? 2'b10 : 2'b00;
      n.sel = (nw < 0) ? m.sel : (nw == 1);
      return n;
   endfunction
   function automatic vec_t mk(logic rn, logic [1:0] r, logic [7:0] a, logic [7:0] b,
                               logic [1:0] g, logic s, logic v, logic [7:0] o);
      vec_t t;
      t.rn = rn; t.req = r; t.d0 = a; t.d1 = b; t.g = g; t.s = s; t.v = v; t.o = o;
      return t;
   endfunction
   task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual{gnt,sel,valid,bus}=%03h required=%03h", nm, act, exp);
      end
   endtask
   task automatic step(input logic rn, input logic [1:0] r, input logic [7:0] a, input logic [7:0] b);
      rst_n = rn;
      b4.req = r; b4.data0 = a; b4.data1 = b;
      b1.req = r; b1.data0 = a; b1.data1 = b;
      @(posedge clk);
      m4 = mstep(m4, 4, rn, r, a, b);
      m1 = mstep(m1, 1, rn, r, a, b);
      #1;
   endtask
   initial begin
      logic [1:0] r;
      logic       rn;
      for (int k = 0; k < 2; k++) begin
         step(1'b0, 2'b11, 8'hAA, 8'h00);
         chk($sformatf("reset%0d", k), {b4.gnt, b4.sel, b4.bus_valid, b4.bus_out}, 12'h000);
      end
      tab.push_back(mk(1, 2'b10, 8'h00, 8'h5C, 2'b10, 1, 0, 8'h00));
      tab.push_back(mk(1, 2'b10, 8'h00, 8'h5C, 2'b10, 1, 1, 8'h5C));
      tab.push_back(mk(1, 2'b10, 8'h00, 8'h5C, 2'b10, 1, 1, 8'h5C));
      tab.push_back(mk(1, 2'b00, 8'h00, 8'h5C, 2'b00, 1, 1, 8'h5C));
      tab.push_back(mk(1, 2'b00, 8'h00, 8'h5C, 2'b00, 1, 0, 8'h5C));
      tab.push_back(mk(1, 2'b01, 8'h11, 8'h00, 2'b01, 0, 0, 8'h5C));
      tab.push_back(mk(1, 2'b11, 8'h22, 8'h99, 2'b01, 0, 1, 8'h22));
      tab.push_back(mk(1, 2'b10, 8'h33, 8'h44, 2'b10, 1, 1, 8'h33));
      tab.push_back(mk(1, 2'b10, 8'h00, 8'h55, 2'b10, 1, 1, 8'h55));
      tab.push_back(mk(1, 2'b00, 8'h00, 8'h66, 2'b00, 1, 1, 8'h66));
      tab.push_back(mk(1, 2'b00, 8'h00, 8'h66, 2'b00, 1, 0, 8'h66));
      tab.push_back(mk(1, 2'b11, 8'hA0, 8'hB0, 2'b01, 0, 0, 8'h66));
      for (int k = 0; k < 3; k++) tab.push_back(mk(1, 2'b11, 8'hA0, 8'hB0, 2'b01, 0, 1, 8'hA0));
      tab.push_back(mk(1, 2'b11, 8'hA0, 8'hB0, 2'b10, 1, 1, 8'hA0));
      for (int k = 0; k < 3; k++) tab.push_back(mk(1, 2'b11, 8'hA0, 8'hB0, 2'b10, 1, 1, 8'hB0));
`ifdef ARB_FIXED_PRIO_EN
      tab.push_back(mk(1, 2'b11, 8'hA0, 8'hB0, 2'b10, 1, 1, 8'hB0));
      tab.push_back(mk(1, 2'b11, 8'hA0, 8'hB0, 2'b10, 1, 1, 8'hB0));
`else
      tab.push_back(mk(1, 2'b11, 8'hA0, 8'hB0, 2'b01, 0, 1, 8'hB0));
      tab.push_back(mk(1, 2'b11, 8'hA0, 8'hB0, 2'b01, 0, 1, 8'hA0));
`endif
      tab.push_back(mk(1, 2'b10, 8'hC0, 8'hC0, 2'b10, 1, 1, 8'hC0));
      tab.push_back(mk(0, 2'b11, 8'hC0, 8'hC0, 2'b00, 0, 0, 8'h00));
      tab.push_back(mk(1, 2'b11, 8'hD1, 8'hE2, 2'b01, 0, 0, 8'h00));
      tab.push_back(mk(1, 2'b11, 8'hD1, 8'hE2, 2'b01, 0, 1, 8'hD1));
      foreach (tab[k]) begin
         step(tab[k].rn, tab[k].req, tab[k].d0, tab[k].d1);
         chk($sformatf("vec%0d", k), {b4.gnt, b4.sel, b4.bus_valid, b4.bus_out},
             {tab[k].g, tab[k].s, tab[k].v, tab[k].o});
      end
      r = 2'b11;
      for (int k = 0; k < 3000; k++) begin
         rn = $urandom_range(0, 63) != 0;
         if ($urandom_range(0, 3) == 0) r = 2'($urandom_range(0, 3));
         step(rn, r, 8'($urandom), 8'($urandom));
         chk($sformatf("rand_h4_%0d", k), {b4.gnt, b4.sel, b4.bus_valid, b4.bus_out},
             {m4.gnt, m4.sel, m4.valid, m4.out});
         chk($sformatf("rand_h1_%0d", k), {b1.gnt, b1.sel, b1.bus_valid, b1.bus_out},
             {m1.gnt, m1.sel, m1.valid, m1.out});
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
